// File: rtl/pr_data_push_ctrl.sv
// pr_data_push_ctrl: partial-reconfiguration data push controller.
// Buffers PR_DATA CSR writes in a first-word-fall-through FIFO, streams them to
// the PR IP over valid/ready, sequences the PR session and reports status,
// transferred-word count and sticky errors back to the CSR block.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   csr_pr_reset        PRReset level; pr_reset_ack is high while in RESET
//   csr_pr_start        PRStartRequest pulse
//   csr_push_complete   PRDataPushComplete pulse
//   csr_data_wr/_data   PR_DATA write strobe and payload; csr_data_ready = FIFO not full
//   pr_start            session-active level to the PR IP
//   pr_valid/_data      FIFO head towards the PR IP, accepted with pr_ready
//   pr_ip_done/_error   PR IP completion / failure
//   pr_status           state encoding (IDLE=0 .. RESET=6)
//   words_pushed        saturating count of words transferred this session
//   err_clr             clears the sticky error flags
//   err_*               sticky overflow / sequence / timeout / IP errors
module pr_data_push_ctrl #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csr_pr_reset,
    output logic              pr_reset_ack,
    input  logic              csr_pr_start,
    input  logic              csr_push_complete,
    input  logic              csr_data_wr,
    input  logic [DATA_W-1:0] csr_data,
    output logic              csr_data_ready,
    output logic              pr_start,
    output logic              pr_valid,
    output logic [DATA_W-1:0] pr_data,
    input  logic              pr_ready,
    input  logic              pr_ip_done,
    input  logic              pr_ip_error,
    output logic [2:0]        pr_status,
    output logic [31:0]       words_pushed,
    input  logic              err_clr,
    output logic              err_overflow,
    output logic              err_seq,
    output logic              err_timeout,
    output logic              err_ip
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ACTIVE    = 3'd1,
        S_DRAIN     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_DONE      = 3'd4,
        S_ERROR     = 3'd5,
        S_RESET     = 3'd6
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_rd_ptr;
    logic [AW-1:0]       r_wr_ptr;
    logic [CW-1:0]       r_count;
    logic [TW-1:0]       r_tmo_cnt;
    logic [31:0]         r_words;
    logic                r_err_ovf;
    logic                r_err_seq;
    logic                r_err_tmo;
    logic                r_err_ip;

    logic w_full;
    logic w_empty;
    logic w_stream;
    logic w_session;
    logic w_pr_valid;
    logic w_xfer;
    logic w_ip_fail;
    logic w_any_err;
    logic w_start_ok;
    logic w_flush;
    logic w_push;
    logic w_pop;
    logic w_tmo_hit;
    logic w_set_ovf;
    logic w_set_seq;
    logic w_set_tmo;
    logic w_set_ip;

    // Datapath and event decode
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_stream   = (r_state == S_ACTIVE) || (r_state == S_DRAIN);
    assign w_session  = w_stream || (r_state == S_WAIT_DONE);
    assign w_pr_valid = w_stream && !w_empty;
    assign w_xfer     = w_pr_valid && pr_ready;
    assign w_ip_fail  = w_session && pr_ip_error;
    assign w_any_err  = r_err_ovf || r_err_seq || r_err_tmo || r_err_ip;
    assign w_start_ok = csr_pr_start &&
                        ((r_state == S_IDLE) || (r_state == S_DONE) ||
                         ((r_state == S_ERROR) && !w_any_err));
    assign w_flush    = csr_pr_reset || w_ip_fail || w_start_ok;
    // Full check uses the registered count, so a same-cycle pop cannot make room
    assign w_push     = csr_data_wr && (r_state == S_ACTIVE) && !w_full && !w_flush;
    assign w_pop      = w_xfer && !w_flush;
    assign w_tmo_hit  = (r_state == S_WAIT_DONE) && !pr_ip_done &&
                        (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));

    assign w_set_ovf  = csr_data_wr && w_full;
    assign w_set_seq  = (csr_data_wr || csr_push_complete) && (r_state != S_ACTIVE);
    assign w_set_tmo  = w_tmo_hit && !w_ip_fail;
    assign w_set_ip   = w_ip_fail;

    // Session FSM, FIFO pointers, word counter and sticky errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_tmo_cnt <= '0;
            r_words   <= '0;
            r_err_ovf <= 1'b0;
            r_err_seq <= 1'b0;
            r_err_tmo <= 1'b0;
            r_err_ip  <= 1'b0;
        end else begin
            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end

            if (w_start_ok && !csr_pr_reset) begin
                r_words <= '0;
            end else if (w_xfer && (r_words != 32'hFFFF_FFFF)) begin
                r_words <= r_words + 32'd1;
            end

            // New error events win over a same-cycle err_clr
            if (csr_pr_reset) begin
                r_err_ovf <= 1'b0;
                r_err_seq <= 1'b0;
                r_err_tmo <= 1'b0;
                r_err_ip  <= 1'b0;
            end else begin
                r_err_ovf <= w_set_ovf || (r_err_ovf && !err_clr);
                r_err_seq <= w_set_seq || (r_err_seq && !err_clr);
                r_err_tmo <= w_set_tmo || (r_err_tmo && !err_clr);
                r_err_ip  <= w_set_ip  || (r_err_ip  && !err_clr);
            end

            if (csr_pr_reset) begin
                r_state <= S_RESET;
            end else if (w_ip_fail) begin
                r_state <= S_ERROR;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (w_start_ok) begin
                            r_state <= S_ACTIVE;
                        end
                    end
                    S_ACTIVE: begin
                        if (csr_push_complete) begin
                            r_state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (w_empty) begin
                            r_state   <= S_WAIT_DONE;
                            r_tmo_cnt <= '0;
                        end
                    end
                    S_WAIT_DONE: begin
                        if (pr_ip_done) begin
                            r_state <= S_DONE;
                        end else if (w_tmo_hit) begin
                            r_state <= S_ERROR;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + TW'(1);
                        end
                    end
                    S_RESET: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // FIFO storage; contents need no reset since pr_data is masked when empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= csr_data;
        end
    end

    // Outputs are pure decodes of registered state
    assign pr_status      = r_state;
    assign pr_reset_ack   = (r_state == S_RESET);
    assign pr_start       = w_session;
    assign pr_valid       = w_pr_valid;
    assign pr_data        = w_pr_valid ? r_mem[r_rd_ptr] : '0;
    assign csr_data_ready = !w_full;
    assign words_pushed   = r_words;
    assign err_overflow   = r_err_ovf;
    assign err_seq        = r_err_seq;
    assign err_timeout    = r_err_tmo;
    assign err_ip         = r_err_ip;

endmodule

// File: tb/tb_pr_data_push_ctrl.sv
// Self-checking bench for pr_data_push_ctrl: a queue-based session model runs
// alongside the DUT and every scenario task compares the DUT output vector to it,
// plus fixed expectations for the named scenarios.
module tb_pr_data_push_ctrl;

    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int TMO   = 4096;

    logic          clk;
    logic          rst;
    logic          csr_pr_reset;
    logic          pr_reset_ack;
    logic          csr_pr_start;
    logic          csr_push_complete;
    logic          csr_data_wr;
    logic [DW-1:0] csr_data;
    logic          csr_data_ready;
    logic          pr_start;
    logic          pr_valid;
    logic [DW-1:0] pr_data;
    logic          pr_ready;
    logic          pr_ip_done;
    logic          pr_ip_error;
    logic [2:0]    pr_status;
    logic [31:0]   words_pushed;
    logic          err_clr;
    logic          err_overflow;
    logic          err_seq;
    logic          err_timeout;
    logic          err_ip;

    pr_data_push_ctrl #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .csr_pr_reset(csr_pr_reset), .pr_reset_ack(pr_reset_ack),
        .csr_pr_start(csr_pr_start), .csr_push_complete(csr_push_complete),
        .csr_data_wr(csr_data_wr), .csr_data(csr_data), .csr_data_ready(csr_data_ready),
        .pr_start(pr_start), .pr_valid(pr_valid), .pr_data(pr_data), .pr_ready(pr_ready),
        .pr_ip_done(pr_ip_done), .pr_ip_error(pr_ip_error),
        .pr_status(pr_status), .words_pushed(words_pushed), .err_clr(err_clr),
        .err_overflow(err_overflow), .err_seq(err_seq),
        .err_timeout(err_timeout), .err_ip(err_ip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [106:0] dut_vec;
    assign dut_vec = {pr_status, pr_reset_ack, pr_start, pr_valid, pr_data, csr_data_ready,
                      words_pushed, err_overflow, err_seq, err_timeout, err_ip};

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: session state number, word queue, sticky flags
    int            m_st;
    logic [DW-1:0] m_q[$];
    logic [31:0]   m_words;
    logic          m_eo, m_es, m_et, m_ei;
    int            m_wait;
    logic [DW-1:0] dut_log[$];

    task automatic model_reset();
        m_st = 0;
        m_q.delete();
        m_words = '0;
        {m_eo, m_es, m_et, m_ei} = 4'b0;
        m_wait = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        logic stream, sess, xfer, any, n_eo, n_es, n_et, n_ei;
        int   sz0;
        if (rst) begin
            model_reset();
            return;
        end
        stream = (m_st == 1) || (m_st == 2);
        sess   = stream || (m_st == 3);
        sz0    = m_q.size();
        xfer   = stream && (sz0 > 0) && pr_ready;
        any    = m_eo | m_es | m_et | m_ei;
        if (xfer && m_words != 32'hFFFF_FFFF) m_words = m_words + 32'd1;
        if (csr_pr_reset) begin
            m_q.delete();
            {m_eo, m_es, m_et, m_ei} = 4'b0;
            m_st = 6;
            return;
        end
        n_eo = csr_data_wr && (sz0 == DEPTH);
        n_es = (csr_data_wr || csr_push_complete) && (m_st != 1);
        n_ei = sess && pr_ip_error;
        n_et = 1'b0;
        if (xfer) void'(m_q.pop_front());
        if (csr_data_wr && m_st == 1 && sz0 < DEPTH) m_q.push_back(csr_data);
        if (n_ei) begin
            m_q.delete();
            m_st = 5;
        end else begin
            case (m_st)
                0, 4: if (csr_pr_start) begin m_q.delete(); m_words = '0; m_st = 1; end
                5:    if (csr_pr_start && !any) begin m_q.delete(); m_words = '0; m_st = 1; end
                1:    if (csr_push_complete) m_st = 2;
                2:    if (sz0 == 0) begin m_st = 3; m_wait = 0; end
                3: begin
                    if (pr_ip_done) m_st = 4;
                    else begin
                        m_wait++;
                        if (m_wait == TMO) begin m_st = 5; n_et = 1'b1; end
                    end
                end
                6:       m_st = 0;
                default: m_st = 0;
            endcase
        end
        m_eo = n_eo | (m_eo & !err_clr);
        m_es = n_es | (m_es & !err_clr);
        m_et = n_et | (m_et & !err_clr);
        m_ei = n_ei | (m_ei & !err_clr);
    endtask

    function automatic logic [106:0] model_vec();
        logic stream, valid;
        logic [DW-1:0] d;
        stream = (m_st == 1) || (m_st == 2);
        valid  = stream && (m_q.size() > 0);
        d      = valid ? m_q[0] : 64'd0;
        return {3'(m_st), (m_st == 6), (stream || m_st == 3), valid, d,
                (m_q.size() < DEPTH), m_words, m_eo, m_es, m_et, m_ei};
    endfunction

    // One clock: log handshakes, advance model, land 1 time unit after the edge
    task automatic step();
        if (pr_valid && pr_ready) dut_log.push_back(pr_data);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_session();
        csr_push_complete = 1'b1; step(); csr_push_complete = 1'b0;
        pr_ready = 1'b1;
        for (int i = 0; i < 64 && m_st != 3; i++) step();
        pr_ip_done = 1'b1; step(); pr_ip_done = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++;
        if (dut_vec !== model_vec()) begin
            n_bad++; $display("FAIL reset_vec: dut=%h exp=%h", dut_vec, model_vec());
        end
        n_vec++;
        if ({pr_status, csr_data_ready, pr_valid, pr_start} !== 6'b000_1_0_0) begin
            n_bad++; $display("FAIL reset_outputs: got %b want 000100",
                              {pr_status, csr_data_ready, pr_valid, pr_start});
        end
    endtask

    task automatic test_nominal();
        dut_log.delete();
        csr_pr_start = 1'b1; step(); csr_pr_start = 1'b0;
        n_vec++;
        if (pr_start !== 1'b1) begin n_bad++; $display("FAIL nominal_start: got %b want 1", pr_start); end
        pr_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            csr_data = 64'(i); csr_data_wr = 1'b1; step();
            n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL nominal_vec: dut=%h exp=%h", dut_vec, model_vec());
            end
            if (i == 1) begin
                n_vec++;
                if (pr_valid !== 1'b1) begin n_bad++; $display("FAIL nominal_first_valid: got %b want 1", pr_valid); end
            end
        end
        csr_data_wr = 1'b0;
        csr_push_complete = 1'b1; step(); csr_push_complete = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL nominal_drain_vec: dut=%h exp=%h", dut_vec, model_vec());
            end
        end
        pr_ip_done = 1'b1; step(); pr_ip_done = 1'b0;
        n_vec++;
        if (dut_log.size() !== 8) begin
            n_bad++; $display("FAIL nominal_count: got %0d words want 8", dut_log.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                n_vec++;
                if (dut_log[j] !== 64'(j + 1)) begin
                    n_bad++; $display("FAIL nominal_data[%0d]: got %h want %h", j, dut_log[j], 64'(j + 1));
                end
            end
        end
        n_vec++;
        if ({pr_status, words_pushed, err_overflow, err_seq, err_timeout, err_ip} !== {3'd4, 32'd8, 4'b0}) begin
            n_bad++; $display("FAIL nominal_end: status=%0d words=%0d errs=%b want 4/8/0000",
                              pr_status, words_pushed, {err_overflow, err_seq, err_timeout, err_ip});
        end
    endtask

    task automatic test_random_stream();
        csr_pr_start = 1'b1; step(); csr_pr_start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            csr_data_wr = ($urandom_range(0, 99) < 60);
            csr_data    = {$urandom(), $urandom()};
            pr_ready    = ($urandom_range(0, 99) < 50);
            err_clr     = ($urandom_range(0, 99) < 3);
            step();
            n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL random_vec[%0d]: dut=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        csr_data_wr = 1'b0; err_clr = 1'b0;
        csr_push_complete = 1'b1; step(); csr_push_complete = 1'b0;
        for (int i = 0; i < 200 && m_st != 3; i++) begin
            pr_ready = ($urandom_range(0, 99) < 50);
            step();
            n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL random_drain_vec: dut=%h exp=%h", dut_vec, model_vec());
            end
        end
        pr_ip_done = 1'b1; step(); pr_ip_done = 1'b0;
        n_vec++;
        if (pr_status !== 3'd4) begin n_bad++; $display("FAIL random_done: status=%0d want 4", pr_status); end
    endtask

    task automatic test_overflow();
        err_clr = 1'b1; step(); err_clr = 1'b0;
        csr_pr_start = 1'b1; step(); csr_pr_start = 1'b0;
        dut_log.delete();
        pr_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            csr_data = 64'h100 + 64'(i); csr_data_wr = 1'b1; step();
            n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL overflow_vec[%0d]: dut=%h exp=%h", i, dut_vec, model_vec());
            end
            if (i == 15) begin
                n_vec++;
                if (csr_data_ready !== 1'b0) begin n_bad++; $display("FAIL overflow_ready: got %b want 0", csr_data_ready); end
            end
        end
        csr_data_wr = 1'b0;
        n_vec++;
        if (err_overflow !== 1'b1) begin n_bad++; $display("FAIL overflow_flag: got %b want 1", err_overflow); end
        pr_ready = 1'b1;
        for (int i = 0; i < 20 && pr_valid === 1'b1; i++) step();
        n_vec++;
        if (dut_log.size() !== 16) begin
            n_bad++; $display("FAIL overflow_count: got %0d words want 16", dut_log.size());
        end else begin
            for (int j = 0; j < 16; j++) begin
                n_vec++;
                if (dut_log[j] !== 64'h100 + 64'(j)) begin
                    n_bad++; $display("FAIL overflow_data[%0d]: got %h want %h", j, dut_log[j], 64'h100 + 64'(j));
                end
            end
        end
        finish_session();
    endtask

    task automatic test_seq_and_ip_error();
        csr_pr_reset = 1'b1; step(); csr_pr_reset = 1'b0; step();
        n_vec++;
        if (pr_status !== 3'd0) begin n_bad++; $display("FAIL seq_idle: status=%0d want 0", pr_status); end
        csr_data = 64'hDEAD; csr_data_wr = 1'b1; step(); csr_data_wr = 1'b0;
        n_vec++;
        if ({err_seq, pr_valid} !== 2'b10) begin
            n_bad++; $display("FAIL seq_idle_write: err_seq=%b pr_valid=%b want 1/0", err_seq, pr_valid);
        end
        csr_pr_start = 1'b1; step(); csr_pr_start = 1'b0;
        pr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            csr_data = {$urandom(), $urandom()}; csr_data_wr = 1'b1; step();
        end
        csr_data_wr = 1'b0;
        pr_ip_error = 1'b1; step(); pr_ip_error = 1'b0;
        n_vec++;
        if ({pr_status, pr_valid, err_ip, csr_data_ready, pr_start} !== {3'd5, 4'b0110}) begin
            n_bad++; $display("FAIL ip_error: st/valid/err_ip/rdy/start=%0d/%b/%b/%b/%b want 5/0/1/1/0",
                              pr_status, pr_valid, err_ip, csr_data_ready, pr_start);
        end
        csr_pr_start = 1'b1; step(); csr_pr_start = 1'b0;
        n_vec++;
        if (pr_status !== 3'd5) begin n_bad++; $display("FAIL restart_blocked: status=%0d want 5", pr_status); end
        err_clr = 1'b1; step(); err_clr = 1'b0;
        csr_pr_start = 1'b1; step(); csr_pr_start = 1'b0;
        n_vec++;
        if (pr_status !== 3'd1) begin n_bad++; $display("FAIL restart_after_clr: status=%0d want 1", pr_status); end
        n_vec++;
        if (dut_vec !== model_vec()) begin
            n_bad++; $display("FAIL seq_vec: dut=%h exp=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_timeout();
        int n;
        csr_push_complete = 1'b1; step(); csr_push_complete = 1'b0;
        for (int i = 0; i < 10 && pr_status !== 3'd3; i++) step();
        n_vec++;
        if (pr_status !== 3'd3) begin n_bad++; $display("FAIL timeout_wait_done: status=%0d want 3", pr_status); end
        n = 0;
        while (pr_status === 3'd3 && n < 5000) begin
            step();
            n++;
            n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL timeout_vec[%0d]: dut=%h exp=%h", n, dut_vec, model_vec());
            end
        end
        n_vec++;
        if (n !== TMO) begin n_bad++; $display("FAIL timeout_cycles: got %0d want %0d", n, TMO); end
        n_vec++;
        if ({pr_status, err_timeout, pr_start} !== {3'd5, 2'b10}) begin
            n_bad++; $display("FAIL timeout_end: status=%0d err_timeout=%b pr_start=%b want 5/1/0",
                              pr_status, err_timeout, pr_start);
        end
    endtask

    task automatic test_reset_mid();
        int logged;
        err_clr = 1'b1; step(); err_clr = 1'b0;
        csr_pr_start = 1'b1; step(); csr_pr_start = 1'b0;
        pr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            csr_data = 64'h200 + 64'(i); csr_data_wr = 1'b1; step();
        end
        csr_data_wr = 1'b0;
        csr_push_complete = 1'b1; step(); csr_push_complete = 1'b0;
        n_vec++;
        if (pr_status !== 3'd2) begin n_bad++; $display("FAIL mid_drain: status=%0d want 2", pr_status); end
        csr_data_wr = 1'b1; step(); csr_data_wr = 1'b0;
        pr_ready = 1'b1; step();
        csr_pr_reset = 1'b1; step();
        logged = dut_log.size();
        n_vec++;
        if ({pr_status, pr_reset_ack, pr_valid, pr_start, err_overflow, err_seq, err_timeout, err_ip}
                !== {3'd6, 7'b1000000}) begin
            n_bad++; $display("FAIL mid_reset: st=%0d ack=%b valid=%b start=%b errs=%b want 6/1/0/0/0000",
                              pr_status, pr_reset_ack, pr_valid, pr_start,
                              {err_overflow, err_seq, err_timeout, err_ip});
        end
        step(); step();
        n_vec++;
        if (dut_log.size() !== logged) begin
            n_bad++; $display("FAIL mid_no_push: got %0d words want %0d", dut_log.size(), logged);
        end
        csr_pr_reset = 1'b0; step();
        n_vec++;
        if ({pr_status, pr_reset_ack} !== 4'b000_0) begin
            n_bad++; $display("FAIL mid_release: status=%0d ack=%b want 0/0", pr_status, pr_reset_ack);
        end
    endtask

    task automatic test_async_rst();
        pr_ready = 1'b0;
        csr_pr_start = 1'b1; step(); csr_pr_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            csr_data = 64'h300 + 64'(i); csr_data_wr = 1'b1; step();
        end
        csr_data_wr = 1'b0;
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (dut_vec !== {3'd0, 3'b000, 64'd0, 1'b1, 32'd0, 4'b0}) begin
            n_bad++; $display("FAIL async_rst: dut=%h want all zero except csr_data_ready", dut_vec);
        end
        step(); step();
        rst = 1'b0;
        step();
        n_vec++;
        if (dut_vec !== model_vec()) begin
            n_bad++; $display("FAIL async_rst_release: dut=%h exp=%h", dut_vec, model_vec());
        end
    endtask

    initial begin
        rst = 1'b1;
        csr_pr_reset = 1'b0; csr_pr_start = 1'b0; csr_push_complete = 1'b0;
        csr_data_wr = 1'b0; csr_data = '0; pr_ready = 1'b0;
        pr_ip_done = 1'b0; pr_ip_error = 1'b0; err_clr = 1'b0;
        model_reset();
        step(); step();
        rst = 1'b0;
        step();

        test_reset();
        test_nominal();
        test_random_stream();
        test_overflow();
        test_seq_and_ip_error();
        test_timeout();
        test_reset_mid();
        test_async_rst();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
